rpc2_ctrl_axid_fifo2: RTL and testbench

Parametrised synchronous FIFO. It is the next-generation ID/tag buffer for the RPC2 controller's AXI read and write channels, replacing the single-threshold ID FIFO. Additions over the previous generation:
- registered occupancy output
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- synchronous flush
- optional first-word-fall-through (FWFT) output stage

---
 rtl/rpc2_ctrl_axid_fifo2_if.sv | 33 +++
 rtl/rpc2_ctrl_axid_fifo2.sv | 137 +++++++++++++
 tb/tb_rpc2_ctrl_axid_fifo2.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rpc2_ctrl_axid_fifo2_if.sv
// Bus bundle for the RPC2 AXI ID/tag FIFO: request, data and status signals.
// The FIFO side uses the slave modport and the user side uses the master modport.
interface rpc2_ctrl_axid_fifo2_if #(
    parameter int FIFO_ADDR_BITS  = 4,
    parameter int FIFO_DATA_WIDTH = 16
);
    // Handshake: a write is taken on an edge where wr_en=1 and full=0, and a read where
    // rd_en=1 and empty=0. Other requests are dropped and raise ovf/udf. clr overrides both.
    logic                       clr;
    logic                       wr_en;
    logic [FIFO_DATA_WIDTH-1:0] wr_data;
    logic                       full;
    logic                       pre_full;
    logic                       afull;
    logic                       rd_en;
    logic [FIFO_DATA_WIDTH-1:0] rd_data;
    logic                       empty;
    logic                       aempty;
    logic [FIFO_ADDR_BITS:0]    level;
    logic                       ovf;
    logic                       udf;
    logic                       err_clr;

    modport master (
        output clr, wr_en, wr_data, rd_en, err_clr,
        input  full, pre_full, afull, rd_data, empty, aempty, level, ovf, udf
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en, err_clr,
        output full, pre_full, afull, rd_data, empty, aempty, level, ovf, udf
    );
endinterface

// File: rtl/rpc2_ctrl_axid_fifo2.sv
// RPC2 AXI ID/tag FIFO with occupancy, almost flags, sticky errors and flush.
// Define RPC2_AXID_FIFO_FWFT_EN to add a first-word-fall-through output stage.
module rpc2_ctrl_axid_fifo2 #(
    parameter int FIFO_ADDR_BITS  = 4,
    parameter int FIFO_DATA_WIDTH = 16,
    parameter int AFULL_THRESH    = (1 << FIFO_ADDR_BITS) - 2,
    parameter int AEMPTY_THRESH   = 1
) (
    input logic                   clk,
    input logic                   rst,
    rpc2_ctrl_axid_fifo2_if.slave bus
);
    localparam int AW    = FIFO_ADDR_BITS;
    localparam int DW    = FIFO_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(DEPTH);
    localparam logic [AW:0]   DEPTH_P  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   DEPTH_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW+1:0] AFULL_W  = (AW+2)'(AFULL_THRESH);
    localparam logic [AW+1:0] AEMPTY_W = (AW+2)'(AEMPTY_THRESH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_rd_data;
    logic          r_full;
    logic          r_afull;
    logic          r_empty;
    logic          r_aempty;
    logic          r_ovf;
    logic          r_udf;

    logic [AW:0]   w_occ;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_mem_pop;
    logic          w_nxt_empty;
    logic [AW+1:0] w_nxt_occ;
    logic [AW+1:0] w_nxt_level;

    assign w_occ    = r_wr_ptr - r_rd_ptr;
    assign w_wr_acc = bus.wr_en & ~r_full;
    assign w_rd_acc = bus.rd_en & ~r_empty;

`ifdef RPC2_AXID_FIFO_FWFT_EN
    logic r_valid;
    logic w_nxt_valid;

    // The stage refills from memory whenever it is vacant or being popped.
    assign w_mem_pop   = (~r_valid | w_rd_acc) & (w_occ != '0);
    assign w_nxt_valid = w_mem_pop | (r_valid & ~w_rd_acc);
    assign w_nxt_empty = ~w_nxt_valid;
    assign w_nxt_level = w_nxt_occ + {{(AW+1){1'b0}}, w_nxt_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (bus.clr) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_nxt_valid;
        end
    end
`else
    assign w_mem_pop   = w_rd_acc;
    assign w_nxt_empty = (w_nxt_occ == '0);
    assign w_nxt_level = w_nxt_occ;
`endif

    assign w_nxt_occ = {1'b0, w_occ} + {{(AW+1){1'b0}}, w_wr_acc}
                                     - {{(AW+1){1'b0}}, w_mem_pop};

    always_ff @(posedge clk) begin
        if (w_wr_acc && !bus.clr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (!bus.clr && w_mem_pop) begin
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else if (bus.clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
        end else begin
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr_acc};
            r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, w_mem_pop};
            r_level  <= w_nxt_level[AW:0];
            r_full   <= (w_nxt_occ == DEPTH_W);
            r_afull  <= (w_nxt_occ >= AFULL_W);
            r_empty  <= w_nxt_empty;
            r_aempty <= (w_nxt_level <= AEMPTY_W);
        end
    end

    // A fresh error in the same cycle as err_clr stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (bus.wr_en & r_full & ~bus.clr) | (r_ovf & ~bus.err_clr);
            r_udf <= (bus.rd_en & r_empty & ~bus.clr) | (r_udf & ~bus.err_clr);
        end
    end

    assign bus.pre_full = ((w_occ == DEPTH_P) & ~bus.rd_en)
                        | ((w_occ == DEPTH_M1) & bus.wr_en & ~bus.rd_en);
    assign bus.full     = r_full;
    assign bus.afull    = r_afull;
    assign bus.empty    = r_empty;
    assign bus.aempty   = r_aempty;
    assign bus.level    = r_level;
    assign bus.rd_data  = r_rd_data;
    assign bus.ovf      = r_ovf;
    assign bus.udf      = r_udf;
endmodule

// File: tb/tb_rpc2_ctrl_axid_fifo2.sv
// Directed bench for rpc2_ctrl_axid_fifo2 at DEPTH=16; read data is checked by a queue-based monitor.
// Standard-mode scenarios run by default; the FWFT scenario runs when RPC2_AXID_FIFO_FWFT_EN is defined.
module tb_rpc2_ctrl_axid_fifo2;
    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    rpc2_ctrl_axid_fifo2_if #(.FIFO_ADDR_BITS(AW), .FIFO_DATA_WIDTH(DW)) bus();

    rpc2_ctrl_axid_fifo2 #(.FIFO_ADDR_BITS(AW), .FIFO_DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr     = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_empty"},   bus.empty,   1);
        chk({tag, "_aempty"},  bus.aempty,  1);
        chk({tag, "_full"},    bus.full,    0);
        chk({tag, "_afull"},   bus.afull,   0);
        chk({tag, "_level"},   bus.level,   0);
        chk({tag, "_ovf"},     bus.ovf,     0);
        chk({tag, "_udf"},     bus.udf,     0);
        chk({tag, "_rd_data"}, bus.rd_data, 0);
    endtask

    // Monitor: every accepted pop is compared with the head of the expected queue.
    always @(posedge clk) begin
        if (!rst && !bus.clr && bus.rd_en && !bus.empty) begin
`ifndef RPC2_AXID_FIFO_FWFT_EN
            #1;
`endif
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_pop actual=0x%0h required=<no word expected>", bus.rd_data);
            end else begin
                chk("sb_rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        idle();
        bus.wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst_hold");
        rst = 1'b0;
        cyc();
        chk_reset("rst_rel");

`ifdef RPC2_AXID_FIFO_FWFT_EN
        // Fall-through latency on a single write
        bus.wr_en = 1'b1; bus.wr_data = 16'h1234; exp_q.push_back(16'h1234);
        cyc();
        bus.wr_en = 1'b0;
        chk("t6_empty_lat1", bus.empty, 1);
        cyc();
        chk("t6_empty_lat2", bus.empty, 0);
        chk("t6_head", bus.rd_data, 16'h1234);
        chk("t6_level1", bus.level, 1);

        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = DW'(16'h1235 + i); exp_q.push_back(DW'(16'h1235 + i));
            cyc();
            chk("t6_level", bus.level, i + 2);
            chk("t6_full", bus.full, (i == 15));
            chk("t6_afull", bus.afull, (i + 1 >= 14));
        end
        bus.wr_data = 16'hDEAD;
        cyc();
        bus.wr_en = 1'b0;
        chk("t6_ovf", bus.ovf, 1);
        chk("t6_level17", bus.level, 17);

        bus.rd_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk("t6_pop_level", bus.level, 17 - k);
            chk("t6_pop_full", bus.full, 0);
            chk("t6_pop_empty", bus.empty, (k == 17));
        end
        bus.rd_en = 1'b0;
        cyc();
`else
        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = DW'(i); exp_q.push_back(DW'(i));
            if (i == 15) chk("t1_pre_full", bus.pre_full, 1);
            if (i == 14) chk("t1_pre_full_lo", bus.pre_full, 0);
            cyc();
            chk("t1_level", bus.level, i + 1);
            chk("t1_afull", bus.afull, (i + 1 >= 14));
            chk("t1_full", bus.full, (i == 15));
            chk("t1_empty", bus.empty, 0);
        end
        bus.wr_data = 16'h00FF;
        cyc();
        bus.wr_en = 1'b0;
        chk("t1_ovf", bus.ovf, 1);
        chk("t1_level_ovf", bus.level, 16);
        chk("t1_full_ovf", bus.full, 1);

        // Drain, then one read too many
        bus.rd_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk("t2_level", bus.level, 16 - k);
            chk("t2_empty", bus.empty, (k == 16));
            chk("t2_aempty", bus.aempty, (16 - k <= 1));
            chk("t2_full", bus.full, 0);
        end
        cyc();
        bus.rd_en = 1'b0;
        chk("t2_udf", bus.udf, 1);
        chk("t2_rd_hold", bus.rd_data, 16'h000F);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("t2_ovf_clr", bus.ovf, 0);
        chk("t2_udf_clr", bus.udf, 0);

        // Simultaneous read/write at level 3 across pointer wrap
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = DW'(16'h0100 + i); exp_q.push_back(DW'(16'h0100 + i));
            cyc();
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.wr_data = DW'(16'h0103 + i); exp_q.push_back(DW'(16'h0103 + i));
            cyc();
            chk("t3_level", bus.level, 3);
        end
        bus.wr_en = 1'b0;
        repeat (3) cyc();
        bus.rd_en = 1'b0;
        chk("t3_empty", bus.empty, 1);
        chk("t3_last", bus.rd_data, 16'h012A);

        // Flush at level 5 with both requests active
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = DW'(16'h0200 + i); exp_q.push_back(DW'(16'h0200 + i));
            cyc();
        end
        chk("t4_level5", bus.level, 5);
        bus.wr_data = 16'h02FF; bus.rd_en = 1'b1; bus.clr = 1'b1;
        cyc();
        idle();
        exp_q.delete();
        chk("t4_level", bus.level, 0);
        chk("t4_empty", bus.empty, 1);
        chk("t4_full", bus.full, 0);
        chk("t4_afull", bus.afull, 0);
        chk("t4_rd_hold", bus.rd_data, 16'h012A);
        bus.wr_en = 1'b1; bus.wr_data = 16'h0300; exp_q.push_back(16'h0300);
        cyc();
        bus.wr_en = 1'b0;
        chk("t4_level_after", bus.level, 1);
        bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
        chk("t4_empty_after", bus.empty, 1);

        // Asynchronous reset mid-burst at level 7 with ovf set
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = DW'(16'h0400 + i); exp_q.push_back(DW'(16'h0400 + i));
            cyc();
        end
        bus.wr_data = 16'h04FF;
        cyc();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        repeat (9) cyc();
        bus.rd_en = 1'b0;
        chk("t5_level7", bus.level, 7);
        chk("t5_ovf_set", bus.ovf, 1);
        bus.wr_en = 1'b1; bus.wr_data = 16'h04AA;
        #2;
        rst = 1'b1;
        #1;
        chk_reset("t5_async");
        exp_q.delete();
        idle();
        cyc();
        rst = 1'b0;
        cyc();
        bus.wr_en = 1'b1; bus.wr_data = 16'hA5A5; exp_q.push_back(16'hA5A5);
        cyc();
        bus.wr_en = 1'b0; bus.rd_en = 1'b1;
        cyc();
        bus.rd_en = 1'b0;
        cyc();
        chk("t5_empty_end", bus.empty, 1);
`endif

        chk("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
